// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing helpers and the output-stage state type for the synchronous FIFO.
package fifo_ctrl_pkg;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra pointer bit tells a full RAM apart from an empty one.
    function automatic int fifo_ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_VALID = 1'b1
    } out_state_e;

endpackage

// File: rtl/fifo_ctrl_dpram.sv
// Simple dual-port RAM: one write port, one registered read port whose output holds between reads.
module dpram #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // rd_data doubles as the FIFO output register, so it must hold when rd_en is low.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointers, occupancy and valid/ready handshakes around a dual-port RAM,
// with a first-word-fall-through output held in the RAM's registered read data.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);
    localparam int PTR_W = fifo_ptr_width(ADDR_WIDTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] ram_cnt;
    logic             ram_full;
    logic             ram_empty;
    logic             push;
    out_state_e       state;
    out_state_e       state_next;

    assign ram_cnt   = wr_ptr - rd_ptr;
    assign ram_full  = (ram_cnt == PTR_W'(DEPTH));
    assign ram_empty = (ram_cnt == '0);

    // s_ready looks only at registered state so it never depends on the consumer side.
    assign s_ready   = !rst && !ram_full;
    assign push      = s_valid && s_ready;

    // Issue a read whenever the output word is absent or leaving this cycle.
    assign ram_rd_en = !rst && !ram_empty && (!m_valid || m_ready);

    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_wr_data = s_data;
    assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign m_data      = ram_rd_data;
    assign count       = ram_cnt + {{(PTR_W-1){1'b0}}, m_valid};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OUT_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            OUT_EMPTY: begin
                if (ram_rd_en) begin
                    state_next = OUT_VALID;
                end
            end
            OUT_VALID: begin
                if (m_ready && !ram_rd_en) begin
                    state_next = OUT_EMPTY;
                end
            end
            default: state_next = OUT_EMPTY;
        endcase
    end

    always_comb begin
        m_valid = (state == OUT_VALID);
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl driving a dpram, covering reset, latency, fill/drain,
// streaming with address wrap, backpressure and mid-operation reset.
module tb_fifo_ctrl;
    import fifo_ctrl_pkg::*;

    localparam int DATA_WIDTH = 2;
    localparam int ADDR_WIDTH = 4;

    logic                  clk;
    logic                  rst;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;
    logic [ADDR_WIDTH:0]   count;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic                  ram_rd_en;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    int checks;
    int failures;

    fifo_ctrl #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .count      (count),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .ram_rd_en  (ram_rd_en),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data)
    );

    dpram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (fifo_depth(ADDR_WIDTH))
    ) ram (
        .clk    (clk),
        .wr_en  (ram_wr_en),
        .wr_addr(ram_wr_addr),
        .wr_data(ram_wr_data),
        .rd_en  (ram_rd_en),
        .rd_addr(ram_rd_addr),
        .rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // One call is one clock cycle; on return the outputs for that cycle are settled.
    task automatic applyStimulus(input logic r, input logic sv, input logic [DATA_WIDTH-1:0] sd,
                                 input logic mr);
        @(posedge clk);
        #1;
        rst     = r;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b0;

        $display("[TB] reset");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd3, 1'b1);
            checkOutput("rst_s_ready", 32'(s_ready), 0);
            checkOutput("rst_wr_en", 32'(ram_wr_en), 0);
            checkOutput("rst_rd_en", 32'(ram_rd_en), 0);
            checkOutput("rst_m_valid", 32'(m_valid), 0);
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("post_rst_s_ready", 32'(s_ready), 1);
        checkOutput("post_rst_m_valid", 32'(m_valid), 0);
        checkOutput("post_rst_count", 32'(count), 0);
        checkOutput("post_rst_rd_en", 32'(ram_rd_en), 0);

        $display("[TB] single word");
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b1);
        checkOutput("sw_wr_en", 32'(ram_wr_en), 1);
        checkOutput("sw_wr_addr", 32'(ram_wr_addr), 0);
        checkOutput("sw_count0", 32'(count), 0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("sw_rd_en", 32'(ram_rd_en), 1);
        checkOutput("sw_rd_addr", 32'(ram_rd_addr), 0);
        checkOutput("sw_m_valid1", 32'(m_valid), 0);
        checkOutput("sw_count1", 32'(count), 1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("sw_m_valid2", 32'(m_valid), 1);
        checkOutput("sw_m_data", 32'(m_data), 3);
        checkOutput("sw_count2", 32'(count), 1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("sw_count3", 32'(count), 0);
        checkOutput("sw_m_valid3", 32'(m_valid), 0);

        $display("[TB] fill and drain");
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1'b0, 1'b1, DATA_WIDTH'(k % 4), 1'b0);
            checkOutput("fill_s_ready", 32'(s_ready), 1);
            checkOutput("fill_count", 32'(count), 32'(k));
        end
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0);
        checkOutput("full_s_ready", 32'(s_ready), 0);
        checkOutput("full_wr_en", 32'(ram_wr_en), 0);
        checkOutput("full_count", 32'(count), 17);
        checkOutput("full_rd_en", 32'(ram_rd_en), 0);
        for (int j = 0; j < 17; j++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
            checkOutput("drain_m_valid", 32'(m_valid), 1);
            checkOutput("drain_m_data", 32'(m_data), 32'(j % 4));
            checkOutput("drain_count", 32'(count), 32'(17 - j));
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("drained_m_valid", 32'(m_valid), 0);
        checkOutput("drained_count", 32'(count), 0);

        // Pointers sit at 18 here (1 word in the single-word test, 17 in the fill).
        $display("[TB] stream with wrap");
        for (int c = 0; c < 43; c++) begin
            applyStimulus(1'b0, (c < 40), DATA_WIDTH'(c % 4), 1'b1);
            checkOutput("st_m_valid", 32'(m_valid), 32'((c >= 2 && c <= 41) ? 1 : 0));
            if (c >= 2 && c <= 41) begin
                checkOutput("st_m_data", 32'(m_data), 32'((c - 2) % 4));
            end
            checkOutput("st_rd_en", 32'(ram_rd_en), 32'((c >= 1 && c <= 40) ? 1 : 0));
            if (c < 40) begin
                checkOutput("st_wr_addr", 32'(ram_wr_addr), 32'((18 + c) % 16));
            end
            if (c >= 1 && c <= 40) begin
                checkOutput("st_rd_addr", 32'(ram_rd_addr), 32'((17 + c) % 16));
            end
            if (c == 0) checkOutput("st_count", 32'(count), 0);
            else if (c == 1) checkOutput("st_count", 32'(count), 1);
            else if (c <= 40) checkOutput("st_count", 32'(count), 2);
            else if (c == 41) checkOutput("st_count", 32'(count), 1);
            else checkOutput("st_count", 32'(count), 0);
        end

        $display("[TB] backpressure");
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0);
        checkOutput("bp_count0", 32'(count), 0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("bp_rd_en0", 32'(ram_rd_en), 1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, DATA_WIDTH'(k % 4), 1'b0);
            checkOutput("bp_m_valid", 32'(m_valid), 1);
            checkOutput("bp_m_data", 32'(m_data), 2);
            checkOutput("bp_rd_en", 32'(ram_rd_en), 0);
            checkOutput("bp_count", 32'(count), 32'(1 + k));
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("bp_count6", 32'(count), 6);
        checkOutput("bp_m_data_hold", 32'(m_data), 2);
        checkOutput("bp_rd_en_pop", 32'(ram_rd_en), 1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("bp_count5", 32'(count), 5);
        checkOutput("bp_next_data", 32'(m_data), 0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b1);
        checkOutput("mr_s_ready", 32'(s_ready), 0);
        checkOutput("mr_rd_en", 32'(ram_rd_en), 0);
        checkOutput("mr_wr_en", 32'(ram_wr_en), 0);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1);
        checkOutput("mr_count", 32'(count), 0);
        checkOutput("mr_m_valid", 32'(m_valid), 0);
        checkOutput("mr_wr_addr", 32'(ram_wr_addr), 0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("mr_rd_en1", 32'(ram_rd_en), 1);
        checkOutput("mr_rd_addr", 32'(ram_rd_addr), 0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("mr_m_valid2", 32'(m_valid), 1);
        checkOutput("mr_m_data", 32'(m_data), 1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        checkOutput("mr_count_end", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
